// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the multiplier operand sequencer.
package mult_seq_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    CALC   = 2'd2,
    HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/mult_operand_sequencer.sv
// Collects two serial operands for an external combinational multiplier,
// registers its product and hands it off over a valid/ready interface.
module mult_operand_sequencer
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   first,
  output logic [WIDTH-1:0]   second,
  input  logic [2*WIDTH-1:0] result,
  output logic [2*WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic [7:0]         op_count
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   first_q, first_d;
  logic [WIDTH-1:0]   second_q, second_d;
  logic [2*WIDTH-1:0] out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         op_count_q, op_count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD_A;
      first_q     <= '0;
      second_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      op_count_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      second_q    <= second_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    second_d    = second_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    op_count_d  = op_count_q;
    in_ready    = (state_q == LOAD_A) || (state_q == LOAD_B);
    busy        = (state_q != LOAD_A);

    case (state_q)
      LOAD_A: begin
        if (in_valid && in_ready) begin
          first_d = in_data;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (in_valid && in_ready) begin
          second_d = in_data;
          state_d  = CALC;
        end
      end
      CALC: begin
        // The multiplier has had a full cycle to settle on the new operands.
        out_data_d  = result;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          op_count_d  = op_count_q + 8'd1;
          state_d     = LOAD_A;
        end
      end
      default: state_d = LOAD_A;
    endcase

    // Abort wins over everything, including a handshake on the same edge.
    if (clear) begin
      state_d     = LOAD_A;
      first_d     = '0;
      second_d    = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
      op_count_d  = op_count_q;
    end
  end

  assign first     = first_q;
  assign second    = second_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Directed scenarios for mult_operand_sequencer with the multiplier modelled inline.
module tb_mult_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  first;
  logic [7:0]  second;
  logic [15:0] result;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic [7:0]  op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign result = {8'd0, first} * {8'd0, second};

  mult_operand_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .first(first), .second(second), .result(result),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .op_count(op_count)
  );

  task automatic apply_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    in_valid = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after the edge that accepted operand B.
  task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_pair_ready: in_ready=%b required 1 within 20 cycles", in_ready);
    end
    in_valid = 1'b1;
    in_data  = a;
    @(posedge clk);
    #1;
    in_data = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready/busy/out_valid=%b required 100", {in_ready, busy, out_valid});
    end
    checks++;
    if ({first, second, out_data, op_count} !== 40'd0) begin
      errors++;
      $display("FAIL reset_regs: first=%h second=%h out_data=%h op_count=%0d required all 0",
               first, second, out_data, op_count);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    apply_reset();
    out_ready = 1'b1;
    send_pair(8'h80, 8'h01);
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b001) begin
      errors++;
      $display("FAIL basic_calc: out_valid/in_ready/busy=%b required 001", {out_valid, in_ready, busy});
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0080) begin
      errors++;
      $display("FAIL basic_result: out_valid=%b out_data=%h required 1 0080", out_valid, out_data);
    end
    checks++;
    if (first !== 8'h80 || second !== 8'h01) begin
      errors++;
      $display("FAIL basic_operands: first=%h second=%h required 80 01", first, second);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || op_count !== 8'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_handshake: out_valid=%b op_count=%0d busy=%b required 0 1 0",
               out_valid, op_count, busy);
    end
    $display("basic: 0x80*0x01 -> %h, op_count=%0d", out_data, op_count);
  endtask

  task automatic test_back_to_back();
    logic [7:0]  av [3] = '{8'h40, 8'h80, 8'h40};
    logic [7:0]  bv [3] = '{8'h80, 8'h80, 8'h20};
    logic [15:0] ev [3] = '{16'h2000, 16'h4000, 16'h0800};
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_pair(av[i], bv[i]);
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== ev[i]) begin
        errors++;
        $display("FAIL b2b_result%0d: out_valid=%b out_data=%h required 1 %h", i, out_valid, out_data, ev[i]);
      end
      $display("b2b[%0d]: %h*%h -> %h", i, av[i], bv[i], out_data);
      @(posedge clk);
      #1;
    end
    checks++;
    if (op_count !== 8'd3) begin
      errors++;
      $display("FAIL b2b_count: op_count=%0d required 3", op_count);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b0;
    send_pair(8'h40, 8'h20);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 8'hFF;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h0800 || in_ready !== 1'b0 ||
          first !== 8'h40 || second !== 8'h20 || op_count !== 8'd0) begin
        errors++;
        $display("FAIL hold_cycle%0d: ov=%b od=%h ir=%b a=%h b=%h cnt=%0d required 1 0800 0 40 20 0",
                 i, out_valid, out_data, in_ready, first, second, op_count);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (op_count !== 8'd1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: op_count=%0d out_valid=%b busy=%b required 1 0 0",
               op_count, out_valid, busy);
    end
    $display("backpressure: released after 5 cycles, op_count=%0d", op_count);
  endtask

  task automatic test_clear();
    apply_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h40;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (first !== 8'h40 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_loadb: first=%h busy=%b required 40 1", first, busy);
    end
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    checks++;
    if (first !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_abort: first=%h busy=%b in_ready=%b out_valid=%b required 00 0 1 0",
               first, busy, in_ready, out_valid);
    end
    send_pair(8'h80, 8'h01);
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0080) begin
      errors++;
      $display("FAIL clear_next: out_valid=%b out_data=%h required 1 0080", out_valid, out_data);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send_pair(8'h02, 8'h03);
    @(posedge clk);
    #1;
    clear     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    checks++;
    if (op_count !== 8'd1 || out_valid !== 1'b0 || out_data !== 16'h0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_vs_handshake: op_count=%0d out_valid=%b out_data=%h busy=%b required 1 0 0000 0",
               op_count, out_valid, out_data, busy);
    end
    $display("clear: abort in LOAD_B and HOLD, op_count=%0d", op_count);
  endtask

  task automatic test_async_reset();
    apply_reset();
    out_ready = 1'b1;
    send_pair(8'h03, 8'h05);
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    send_pair(8'h07, 8'h09);
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h003F || op_count !== 8'd1) begin
      errors++;
      $display("FAIL areset_pre: out_valid=%b out_data=%h op_count=%0d required 1 003f 1",
               out_valid, out_data, op_count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || op_count !== 8'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_now: out_valid=%b op_count=%0d busy=%b in_ready=%b required 0 0 0 1",
               out_valid, op_count, busy, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("async reset: out_valid=%b op_count=%0d", out_valid, op_count);
  endtask

  task automatic test_wrap();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      send_pair(8'h01, 8'h01);
      repeat (2) @(posedge clk);
      #1;
      if (i == 255) begin
        checks++;
        if (op_count !== 8'd255) begin
          errors++;
          $display("FAIL wrap_255: op_count=%0d required 255", op_count);
        end
      end
    end
    checks++;
    if (op_count !== 8'd0) begin
      errors++;
      $display("FAIL wrap_0: op_count=%0d required 0", op_count);
    end
    $display("wrap: after 256 ops op_count=%0d", op_count);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
